pipe_mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide controller with HI/LO registers for the 5-stage pipeline. It sits beside the EXE-stage ALU and takes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from EXE. It runs an iterative shift-add multiply or restoring divide and drives a stall that freezes IF/ID/EXE only when a later HI/LO-touching op arrives while it is busy. Independent ALU instructions keep flowing during an operation.

---
 rtl/pipe_mdu_pkg.sv | 19 +
 rtl/pipe_mdu_ctrl_step.sv | 24 ++
 rtl/pipe_mdu_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_mdu_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mdu_pkg.sv
// pipe_mdu_pkg: op and state encodings shared by the multiply/divide controller.
package pipe_mdu_pkg;
  localparam int MDU_WIDTH = 32;
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} mdu_state_e;
  function automatic logic is_mdu_op(input logic [3:0] op);
    return op inside {[4'd1:4'd8]};
  endfunction
endpackage

// File: rtl/pipe_mdu_ctrl_step.sv
// mdu_step: one shift-add multiply or restoring-divide iteration on magnitudes.
module mdu_step
  import pipe_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             i_div,
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_opnd,
  input  logic [WIDTH-1:0] i_mag,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_opnd
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH+1:0] w_diff;
  always_comb begin
    w_sum  = i_acc + (i_opnd[0] ? {1'b0, i_mag} : '0);
    w_shl  = {i_acc[WIDTH-1:0], i_opnd[WIDTH-1]};
    w_diff = {1'b0, w_shl} - {2'b0, i_mag};
    o_acc  = i_div ? (w_diff[WIDTH+1] ? w_shl : w_diff[WIDTH:0]) : {1'b0, w_sum[WIDTH:1]};
    o_opnd = i_div ? {i_opnd[WIDTH-2:0], ~w_diff[WIDTH+1]} : {w_sum[0], i_opnd[WIDTH-1:1]};
  end
endmodule

// File: rtl/pipe_mdu_ctrl.sv
// pipe_mdu_ctrl: iterative MULT/DIV unit with HI/LO and EXE stall control.
// Define PIPE_MDU_EARLY_OUT_EN to finish multiplies once the remaining multiplier bits are zero.
module pipe_mdu_ctrl
  import pipe_mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [3:0]       eop,
  input  logic             eadvance,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  output logic             mdu_stall,
  output logic             mdu_busy,
  output logic [WIDTH-1:0] mdu_result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  mdu_state_e r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH:0] r_acc, w_acc;
  logic [WIDTH-1:0] r_op, w_op, r_mag, r_hi, r_lo;
  logic r_div, r_negq, r_negr;
  logic w_accept, w_muldiv, w_isdiv, w_signed, w_dz, w_ea_neg, w_eb_neg, w_last, w_eo;
  logic [WIDTH-1:0] w_ea_abs, w_eb_abs, w_quo, w_rem, w_hi_fix, w_lo_fix;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH:0] w_sh;
  assign mdu_busy   = r_state != ST_IDLE;
  assign mdu_stall  = mdu_busy & is_mdu_op(eop);
  assign w_accept   = eadvance & ~mdu_stall & is_mdu_op(eop);
  assign w_muldiv   = eop inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
  assign w_isdiv    = eop inside {MDU_DIV, MDU_DIVU};
  assign w_signed   = eop inside {MDU_MULT, MDU_DIV};
  assign w_dz       = w_isdiv & (eb == '0);
  assign w_ea_neg   = w_signed & ea[WIDTH-1];
  assign w_eb_neg   = w_signed & eb[WIDTH-1];
  assign w_ea_abs   = w_ea_neg ? -ea : ea;
  assign w_eb_abs   = w_eb_neg ? -eb : eb;
  assign mdu_result = eop == MDU_MFHI ? r_hi : eop == MDU_MFLO ? r_lo : '0;
  assign hi         = r_hi;
  assign lo         = r_lo;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_div (r_div),
    .i_acc (r_acc),
    .i_opnd(r_op),
    .i_mag (r_mag),
    .o_acc (w_acc),
    .o_opnd(w_op)
  );

`ifdef PIPE_MDU_EARLY_OUT_EN
  logic [WIDTH-1:0] w_ones;
  assign w_ones = '1;
  // Unprocessed multiplier bits sit just above bit 0 of r_op; once they are zero the rest is pure shifting.
  assign w_eo = ~r_div & (((r_op >> 1) & ((w_ones >> 1) >> r_cnt)) == '0);
  assign w_sh = {w_acc, w_op} >> (LAST - r_cnt);
`else
  assign w_eo = 1'b0;
  assign w_sh = {w_acc, w_op};
`endif
  assign w_last = (r_cnt == LAST) | w_eo;

  always_comb begin
    w_next   = r_state == ST_IDLE ? (w_accept && w_muldiv ? (w_dz ? ST_FIX : ST_RUN) : ST_IDLE)
             : r_state == ST_RUN  ? (w_last ? ST_FIX : ST_RUN) : ST_IDLE;
    w_prod   = {r_acc[WIDTH-1:0], r_op};
    w_prod   = r_negq ? -w_prod : w_prod;
    w_quo    = r_negq ? -r_op : r_op;
    w_rem    = r_negr ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_hi_fix = r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    w_lo_fix = r_div ? w_quo : w_prod[WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_op    <= '0;
      r_mag   <= '0;
      r_div   <= 1'b0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_accept) begin
        if (w_muldiv) begin
          // Divide by zero skips RUN: HI=dividend, LO=all ones, no sign fix.
          r_div  <= w_isdiv;
          r_cnt  <= '0;
          r_acc  <= w_dz ? {1'b0, ea} : '0;
          r_op   <= w_dz ? '1 : w_isdiv ? w_ea_abs : w_eb_abs;
          r_mag  <= w_isdiv ? w_eb_abs : w_ea_abs;
          r_negq <= ~w_dz & (w_ea_neg ^ w_eb_neg);
          r_negr <= ~w_dz & w_isdiv & w_ea_neg;
        end
        if (eop == MDU_MTHI) r_hi <= ea;
        if (eop == MDU_MTLO) r_lo <= ea;
      end else if (r_state == ST_RUN) begin
        r_acc <= w_sh[2*WIDTH:WIDTH];
        r_op  <= w_sh[WIDTH-1:0];
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == ST_FIX) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
    end
  end
endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// tb_pipe_mdu_ctrl: vector table plus scoreboard bench for the multiply/divide controller.
module tb_pipe_mdu_ctrl;
  import pipe_mdu_pkg::*;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [3:0] eop = 4'd0;
  logic eadvance = 1'b0;
  logic [31:0] ea = '0, eb = '0;
  logic mdu_stall, mdu_busy;
  logic [31:0] mdu_result, hi, lo;

  typedef struct { logic [3:0] op; logic [31:0] a, b, hi, lo; int busy; } vec_t;
  typedef struct { logic [31:0] hi, lo; int busy; } sb_t;
  vec_t vt[14];
  sb_t sbq[$];
  int n_vec = 0, n_bad = 0;

  pipe_mdu_ctrl dut (
    .clock(clock), .resetn(resetn), .eop(eop), .eadvance(eadvance), .ea(ea), .eb(eb),
    .mdu_stall(mdu_stall), .mdu_busy(mdu_busy), .mdu_result(mdu_result), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    if ((op == MDU_DIV || op == MDU_DIVU) && b == 0) return {a, 32'hFFFF_FFFF};
    case (op)
      MDU_MULT:  p = 64'(sa * sb);
      MDU_MULTU: p = {32'b0, a} * {32'b0, b};
      MDU_DIV:   begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      default:   begin q = ua / ub; r = ua % ub; p = {r[31:0], q[31:0]}; end
    endcase
    return p;
  endfunction

  function automatic int exp_busy(input logic [3:0] op, input logic [31:0] b);
    logic [31:0] m;
    int top;
    if ((op == MDU_DIV || op == MDU_DIVU) && b == 0) return 1;
    m = (op == MDU_MULT && b[31]) ? -b : b;
    top = 0;
    for (int i = 0; i < 32; i++) if (m[i]) top = i;
`ifdef PIPE_MDU_EARLY_OUT_EN
    if (op == MDU_MULT || op == MDU_MULTU) return top + 2;
`endif
    return (top >= 0) ? 33 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m;
    m = model(op, a, b);
    sbq.push_back('{m[63:32], m[31:0], exp_busy(op, b)});
  endtask

  // Presents a mul/div op for one idle cycle; it is accepted at the next rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    eop = op; ea = a; eb = b; eadvance = 1'b1;
    push_exp(op, a, b);
    @(posedge clock); #1;
    eop = MDU_NONE;
  endtask

  task automatic wait_done(input string nm);
    sb_t e;
    int n;
    n = 0;
    @(negedge clock);
    while (mdu_busy && n < 100) begin
      if (n == 0) chk({nm, " indep stall"}, {31'b0, mdu_stall}, 32'd0);
      n++;
      @(negedge clock);
    end
    if (sbq.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sbq.pop_front();
    chk({nm, " busy cycles"}, 32'(n), 32'(e.busy));
    chk({nm, " hi"}, hi, e.hi);
    chk({nm, " lo"}, lo, e.lo);
  endtask

  initial begin
    sb_t e;
    int n;
    vt[0]  = '{MDU_MULT,  32'hFFFF_FFFF, 32'd7,         0, 0, 0};
    vt[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0};
    vt[2]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0, 0};
    vt[3]  = '{MDU_MULT,  32'h1234_5678, 32'hFFFF_FFFD, 0, 0, 0};
    vt[4]  = '{MDU_MULTU, 32'd0,         32'h1234,      0, 0, 0};
    vt[5]  = '{MDU_MULTU, 32'h1234,      32'd1,         0, 0, 0};
    vt[6]  = '{MDU_DIVU,  32'd100,       32'd7,         0, 0, 0};
    vt[7]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0};
    vt[8]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0, 0};
    vt[9]  = '{MDU_DIVU,  32'h1234,      32'd0,         0, 0, 0};
    vt[10] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 0, 0, 0};
    vt[11] = '{MDU_DIV,   32'hFFFF_FF9C, 32'd0,         0, 0, 0};
    vt[12] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd3,         0, 0, 0};
    vt[13] = '{MDU_MULT,  32'h8000_0000, 32'd1,         0, 0, 0};
    vt[0].hi = 32'hFFFF_FFFF; vt[0].lo = 32'hFFFF_FFF9;
    vt[7].hi = 32'd0;         vt[7].lo = 32'h8000_0000;
    vt[8].hi = 32'hFFFF_FFFF; vt[8].lo = 32'hFFFF_FFFD;
    vt[9].hi = 32'h1234;      vt[9].lo = 32'hFFFF_FFFF;
    for (int i = 0; i < 14; i++) if (!(i inside {0, 7, 8, 9})) {vt[i].hi, vt[i].lo} = model(vt[i].op, vt[i].a, vt[i].b);
    for (int i = 0; i < 14; i++) vt[i].busy = exp_busy(vt[i].op, vt[i].b);

    eop = MDU_MFHI;
    repeat (2) @(posedge clock);
    #1;
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset busy", {31'b0, mdu_busy}, 0);
    chk("reset stall", {31'b0, mdu_stall}, 0);
    chk("reset result", mdu_result, 0);
    @(negedge clock);
    resetn = 1'b1;
    eop = MDU_NONE;

    for (int i = 0; i < 14; i++) begin
      eop = vt[i].op; ea = vt[i].a; eb = vt[i].b; eadvance = 1'b1;
      sbq.push_back('{vt[i].hi, vt[i].lo, vt[i].busy});
      @(posedge clock); #1;
      eop = MDU_NONE;
      wait_done($sformatf("vec%0d", i));
      @(posedge clock); #1;
      eop = MDU_MFHI;
      @(negedge clock);
      chk($sformatf("vec%0d mfhi", i), mdu_result, vt[i].hi);
      @(posedge clock); #1;
      eop = MDU_MFLO;
      @(negedge clock);
      chk($sformatf("vec%0d mflo", i), mdu_result, vt[i].lo);
      @(posedge clock); #1;
      eop = MDU_NONE;
    end

    // MFLO held behind a DIVU until the result lands
    issue(MDU_DIVU, 32'd100, 32'd7);
    @(posedge clock); #1;
    eop = MDU_MFLO;
    n = 0;
    @(negedge clock);
    while (mdu_stall && n < 100) begin n++; @(negedge clock); end
    chk("mflo stall cycles", 32'(n), 32'(exp_busy(MDU_DIVU, 32'd7) - 1));
    chk("mflo after div", mdu_result, 32'd14);
    e = sbq.pop_front();
    @(posedge clock); #1;
    eop = MDU_MFHI;
    @(negedge clock);
    chk("mfhi after div", mdu_result, 32'd2);
    @(posedge clock); #1;

    // Op presented during FIX stalls that cycle and is accepted the next
    issue(MDU_DIVU, 32'h1234, 32'd0);
    eop = MDU_MULTU; ea = 32'h0001_0003; eb = 32'h0002_0005;
    @(negedge clock);
    chk("fix stall", {31'b0, mdu_stall}, 1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("post fix stall", {31'b0, mdu_stall}, 0);
    e = sbq.pop_front();
    chk("dz hi", hi, e.hi);
    chk("dz lo", lo, e.lo);
    push_exp(MDU_MULTU, 32'h0001_0003, 32'h0002_0005);
    @(posedge clock); #1;
    eop = MDU_NONE;
    wait_done("fix accept");

    // MULTU held by eadvance, then MTHI queued behind it
    @(posedge clock); #1;
    eop = MDU_MULTU; ea = 32'h1234_5678; eb = 32'h0000_9ABC; eadvance = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("held no busy", {31'b0, mdu_busy}, 0);
    end
    eadvance = 1'b1;
    push_exp(MDU_MULTU, 32'h1234_5678, 32'h0000_9ABC);
    @(posedge clock); #1;
    eop = MDU_MTHI; ea = 32'h55;
    n = 0;
    @(negedge clock);
    while (mdu_stall && n < 100) begin n++; @(negedge clock); end
    e = sbq.pop_front();
    chk("mthi stall cycles", 32'(n), 32'(e.busy));
    chk("held mul hi", hi, e.hi);
    chk("held mul lo", lo, e.lo);
    @(posedge clock); #1;
    eop = MDU_NONE;
    chk("mthi hi", hi, 32'h55);
    chk("mthi keeps lo", lo, e.lo);
    @(negedge clock);
    chk("single exec", {31'b0, mdu_busy}, 0);

    // Asynchronous reset in the middle of RUN
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    void'(sbq.pop_front());
    repeat (9) @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid reset busy", {31'b0, mdu_busy}, 0);
    chk("mid reset hi", hi, 0);
    chk("mid reset lo", lo, 0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("after reset busy", {31'b0, mdu_busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
